subtrator_serial: RTL and testbench
===================================

// Module: subtrator_serial
// PURPOSE
//   Bit-serial subtractor: computes d = a - b - bin one bit per clock, LSB first, using a
//   single full-subtractor cell and a borrow flip-flop. Counterpart of the ripple adders in
//   this project; trades latency for area. Results are reported with a start/busy/done handshake.
// PARAMETERS
//   WIDTH  3  operand and result width in bits (WIDTH >= 1)
// PORTS
//   clk    in   1      clock, all state updates on rising edge
//   rst_n  in   1      synchronous reset, active-low
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   bin    in   1      borrow in (1 = subtract one more), captured on accepted start
//   busy   out  1      1 while bits are being processed (state SHIFT)
//   done   out  1      one-cycle pulse: d/bout valid
//   d      out  WIDTH  difference, registered
//   bout   out  1      borrow out (1 = result negative / underflow), registered
// BEHAVIOUR
//   Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, d=0, bout=0,
//     internal shift regs, borrow FF and bit counter cleared. Reset wins over everything,
//     including mid-operation; the aborted operation produces no done pulse.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE : start=1 -> load a,b into shift regs, borrow FF <= bin, cnt <= 0, go SHIFT.
//            start=0 -> stay. d/bout keep last result.
//     SHIFT: per cycle, with x=a_sr[0], y=b_sr[0], r=borrow FF:
//              diff = x ^ y ^ r ; r' = (~x & y) | (~(x ^ y) & r)
//            diff shifted into d result register from MSB side (after WIDTH shifts bit 0
//            lands at d[0]); a_sr, b_sr shift right; borrow FF <= r'; cnt++.
//            When cnt == WIDTH-1 this cycle: bout <= r', go DONE.
//     DONE : done=1 for exactly this cycle, then IDLE unconditionally.
//   Outputs: busy = (state==SHIFT); done = (state==DONE); both registered-state decodes.
//   Latency: start sampled at edge k -> busy high for cycles k+1..k+WIDTH, done high in
//     cycle k+WIDTH+1. Next start can be accepted at edge k+WIDTH+2 (first IDLE cycle).
//   start while SHIFT or DONE: ignored (no queueing); a,b,bin changes during SHIFT have no effect.
//   d is updated only by completed operations' shift sequence; d is intermediate (partially
//     shifted) while busy=1 and must only be consumed when done=1 or in IDLE afterwards.
//   Arithmetic: {bout,d} == (a - b - bin) mod 2^(WIDTH+1) interpreted with bout as the
//     2^WIDTH borrow; i.e. d = (a - b - bin) mod 2^WIDTH, bout = (a < b + bin).
//   WIDTH=1: SHIFT lasts one cycle; counter width is max(1,$clog2(WIDTH)).
// TESTING (instance WIDTH=4 unless stated)
//   1. a=9,b=3,bin=0, start pulse at edge k -> busy k+1..k+4, done at k+5, d=6, bout=0.
//   2. a=3,b=9,bin=0 -> done at k+5, d=4'hA, bout=1.
//   3. a=0,b=0,bin=1 -> d=4'hF, bout=1; a=15,b=15,bin=0 -> d=0, bout=0.
//   4. start held high during SHIFT with new a/b -> first result unaffected (9-3=6), then
//      exactly one new op begins at first IDLE edge; done pulses are exactly one cycle wide.
//   5. rst_n=0 for one edge at cycle k+2 of an op -> next cycle busy=0,done=0,d=0,bout=0,
//      no done pulse; a fresh op (7-2) then completes with d=5, bout=0.
//   6. Exhaustive sweep WIDTH=3: all a,b in 0..7, bin in {0,1}, back-to-back starts ->
//      d,bout match (a-b-bin) model every time.

Source files
------------

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// start/busy/done handshake; d/bout hold the last completed result while idle.
module subtrator_serial #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             x, y, diff, brw_nx, last;
  logic [WIDTH:0]   d_shift;

  assign x       = a_sr[0];
  assign y       = b_sr[0];
  assign diff    = x ^ y ^ brw;
  assign brw_nx  = (~x & y) | (~(x ^ y) & brw);
  assign last    = (cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH shifts the first bit sits at d[0].
  // The extra bit keeps the slice legal for WIDTH=1.
  assign d_shift = {diff, d};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr <= a;
          b_sr <= b;
          brw  <= bin;
          cnt  <= '0;
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          brw  <= brw_nx;
          cnt  <= cnt + CW'(1);
          d    <= d_shift[WIDTH:1];
          if (last) bout <= brw_nx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_subtrator_serial.sv
// Bench for subtrator_serial: WIDTH=4 directed/random ops and a WIDTH=3 exhaustive sweep,
// checked against plain integer a-b-bin arithmetic.
module tb_subtrator_serial;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, d4;
  logic       start3, bin3, busy3, done3, bout3;
  logic [2:0] a3, b3, d3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  subtrator_serial #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .d(d4), .bout(bout4)
  );

  subtrator_serial #(.WIDTH(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .d(d3), .bout(bout3)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int o_busy(input bit w3); return w3 ? int'(busy3) : int'(busy4); endfunction
  function automatic int o_done(input bit w3); return w3 ? int'(done3) : int'(done4); endfunction
  function automatic int o_d(input bit w3);    return w3 ? int'(d3)    : int'(d4);    endfunction
  function automatic int o_bout(input bit w3); return w3 ? int'(bout3) : int'(bout4); endfunction

  task automatic drive(input bit w3, input bit s, input int av, input int bv, input int bi);
    if (w3) begin start3 = s; a3 = 3'(av); b3 = 3'(bv); bin3 = bi[0]; end
    else    begin start4 = s; a4 = 4'(av); b4 = 4'(bv); bin4 = bi[0]; end
  endtask

  function automatic int ref_d(input int w, input int av, input int bv, input int bi);
    return (av - bv - bi) & ((1 << w) - 1);
  endfunction

  function automatic int ref_bout(input int w, input int av, input int bv, input int bi);
    return (av < bv + bi) ? 1 : 0;
  endfunction

  // Starts an op from IDLE and checks the full timeline; returns in the first IDLE cycle.
  task automatic run_op(input bit w3, input int av, input int bv, input int bi, input string tag);
    int w;
    w = w3 ? 3 : 4;
    drive(w3, 1'b1, av, bv, bi);
    tick();
    drive(w3, 1'b0, 0, 0, 0);
    for (int i = 0; i < w; i++) begin
      chk({tag, ".busy"}, o_busy(w3), 1);
      chk({tag, ".nodone"}, o_done(w3), 0);
      tick();
    end
    chk({tag, ".done"}, o_done(w3), 1);
    chk({tag, ".busy_off"}, o_busy(w3), 0);
    chk({tag, ".d"}, o_d(w3), ref_d(w, av, bv, bi));
    chk({tag, ".bout"}, o_bout(w3), ref_bout(w, av, bv, bi));
    tick();
    chk({tag, ".pulse1"}, o_done(w3), 0);
  endtask

  initial begin
    int av, bv, bi, gap, hd, hb;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 0, 0);
    tick();
    tick();
    chk("rst.busy4", busy4, 0);
    chk("rst.done4", done4, 0);
    chk("rst.d4", d4, 0);
    chk("rst.bout4", bout4, 0);
    chk("rst.busy3", busy3, 0);
    chk("rst.d3", d3, 0);
    rst_n = 1'b1;
    tick();

    run_op(1'b0, 9, 3, 0, "t1");
    run_op(1'b0, 3, 9, 0, "t2");
    run_op(1'b0, 0, 0, 1, "t3a");
    run_op(1'b0, 15, 15, 0, "t3b");
    chk("hold.d", d4, 0);

    // start held high through an op with changing operands
    drive(1'b0, 1'b1, 9, 3, 0);
    tick();
    drive(1'b0, 1'b1, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4.busy", busy4, 1);
      tick();
    end
    chk("t4.done", done4, 1);
    chk("t4.d", d4, 6);
    chk("t4.bout", bout4, 0);
    tick();
    chk("t4.idle_busy", busy4, 0);
    chk("t4.idle_done", done4, 0);
    chk("t4.idle_d", d4, 6);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4.op2_busy", busy4, 1);
      chk("t4.op2_nodone", done4, 0);
      tick();
    end
    chk("t4.op2_done", done4, 1);
    chk("t4.op2_d", d4, 0);
    tick();
    chk("t4.op2_pulse1", done4, 0);
    chk("t4.no_third", busy4, 0);

    // reset mid-operation
    run_op(1'b0, 14, 3, 0, "t5pre");
    drive(1'b0, 1'b1, 9, 3, 0);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5.busy", busy4, 0);
    chk("t5.done", done4, 0);
    chk("t5.d", d4, 0);
    chk("t5.bout", bout4, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t5.nodone", done4, 0);
      chk("t5.nobusy", busy4, 0);
      tick();
    end
    run_op(1'b0, 7, 2, 0, "t5b");

    // random ops with idle gaps; result must hold while idle
    for (int n = 0; n < 40; n++) begin
      av = int'($urandom_range(15));
      bv = int'($urandom_range(15));
      bi = int'($urandom_range(1));
      run_op(1'b0, av, bv, bi, "rnd");
      hd = ref_d(4, av, bv, bi);
      hb = ref_bout(4, av, bv, bi);
      gap = int'($urandom_range(3));
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("rnd.hold_d", d4, hd);
        chk("rnd.hold_bout", bout4, hb);
        chk("rnd.idle_busy", busy4, 0);
      end
    end

    // exhaustive WIDTH=3, back-to-back
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int c = 0; c < 2; c++)
          run_op(1'b1, x, y, c, "w3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
